prog_ctrl_mc: RTL
=================

Name: prog_ctrl_mc

Overview:
- Next-generation debug-port memory programming controller.
- Accepts single-word read/write requests from the debug transport (already synchronised into the clk domain) and arbitrates them onto one of N_TGT on-chip memories (e.g. IMEM, DMEM, boot ROM shadow).
- Adds over the previous generation: byte-enable writes, address auto-increment for streaming, configurable read latency, out-of-range error responses, and a parametrised CPU reset hold on exit.
- Sits between the debug TAP CDC layer and the memory muxes in the SoC top.

Parameters:
- ADDR_W, 10, word-address width per target memory.
- DATA_W, 32, data word width (multiple of 8).
- N_TGT, 2, number of target memories (1..8).
- TGT_W, 3, width of the target-select field.
- RD_LAT, 1, memory read latency in cycles (1..4).
- RST_HOLD, 4, cycles cpu_rst is held after debug mode exits (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- dbg_en  in  1  debug/programming mode request, level.
- req_valid  in  1  request strobe; accepted when req_valid & req_ready.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_incr  in  1  1 = use internal address pointer; ignore req_addr.
- req_tgt  in  TGT_W  target memory index.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  response error flag, valid with rsp_valid.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; held until next response.
- mem_ctrl_en  out  1  memories are muxed to this controller.
- mem_sel  out  N_TGT  one-hot target strobe.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  N_TGT*DATA_W  per-target read data; target i occupies slice [i*DATA_W +: DATA_W].
- cpu_rst  out  1  CPU reset request, active-high.

Behaviour:
- Reset values:
  - All outputs 0, except cpu_rst = 0.
  - State IDLE; address pointer 0; latched target 0.
- FSM states and transitions:
  - IDLE: mem_ctrl_en = 0. Go to CTRL when dbg_en = 1.
  - CTRL: req_ready = 1 (req_ready is 1 only in CTRL).
    - dbg_en = 0 → RELEASE; a req_valid in the same cycle is not accepted.
    - Handshake → ACCESS. Latch we, tgt, be, wdata. Latch address = req_incr ? ptr : req_addr.
  - ACCESS: one cycle.
    - If tgt >= N_TGT → RESP with error; no mem strobe.
    - Write: mem_sel[tgt] = 1, mem_we = 1, mem_be = latched be → RESP.
    - Read: mem_sel[tgt] = 1, mem_re = 1 → WAIT_RD.
  - WAIT_RD: count RD_LAT cycles, then capture mem_rdata slice of tgt into rsp_rdata → RESP.
  - RESP: rsp_valid = 1 for exactly one cycle.
    - rsp_err = 1 for out-of-range target; rsp_rdata = 0 on error and on writes.
    - ptr = latched address + 1 (wraps mod 2^ADDR_W, also after an error).
    - → CTRL.
  - RELEASE: cpu_rst = 1 for exactly RST_HOLD cycles (counter), mem_ctrl_en still 1, then → IDLE.
- Latency: write request accept → rsp_valid in 2 cycles; read request → 2 + RD_LAT cycles.
- mem_ctrl_en = 1 in every state except IDLE.
- mem_addr, mem_wdata and mem_be hold their last values when no strobe is active.
- dbg_en falling during ACCESS, WAIT_RD or RESP: the transaction completes and responds normally, then the controller goes to RELEASE.
- dbg_en re-asserted during RELEASE: ignored until IDLE; the next cycle in IDLE enters CTRL.
- rst asserted in any state, including mid-read: immediate return to IDLE with all outputs at reset values; no response is issued.

Decomposition:
- Shared package prog_pkg holds:
  - state typedef (IDLE, CTRL, ACCESS, WAIT_RD, RESP, RELEASE), 3-bit encoding;
  - localparam limits for RD_LAT and RST_HOLD.
- One natural sub-module, prog_rd_mux: combinational N_TGT-way read-data selector indexed by the latched target.

Test Plan:
- Write tgt=0 addr=0x005 data=0xDEADBEEF be=4'b1111 → mem_sel=2'b01, mem_we=1 for 1 cycle, mem_addr=0x005; rsp_valid 2 cycles after accept, rsp_err=0.
- Read tgt=1 addr=0x3FF with RD_LAT=2, memory returns 0xCAFEF00D → rsp_valid 4 cycles after accept, rsp_rdata=0xCAFEF00D. Then an incr read → mem_addr=0x000 (wrap).
- Three incr writes after a write to addr 0x010 → mem_addr 0x011, 0x012, 0x013 in sequence; be=4'b0011 → mem_be=4'b0011.
- Request with tgt=5 (N_TGT=2) → no mem_sel/mem_we/mem_re activity; rsp_err=1, rsp_rdata=0; next incr access uses ptr+1.
- Drop dbg_en during WAIT_RD → read response still delivered; then cpu_rst high for exactly RST_HOLD=4 cycles; mem_ctrl_en falls on the IDLE cycle.
- Assert rst during WAIT_RD → next cycle all outputs 0, state IDLE, no rsp_valid; with dbg_en held high, CTRL is re-entered after rst deasserts.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared types and limits for the debug-port memory programming controller.
//   state_t    : controller FSM state, 3-bit encoding
//   *_MIN/_MAX : legal ranges for read latency and CPU reset hold
//   clamp()    : folds an out-of-range parameter back into its legal range
package prog_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL    = 3'd1,
    ACCESS  = 3'd2,
    WAIT_RD = 3'd3,
    RESP    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam int RD_LAT_MIN   = 1;
  localparam int RD_LAT_MAX   = 4;
  localparam int RST_HOLD_MIN = 2;
  localparam int RST_HOLD_MAX = 255;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/prog_rd_mux.sv
// N_TGT-way read-data selector.
//   rdata : concatenated per-target read words, target i at [i*DATA_W +: DATA_W]
//   sel   : target index (only meaningful when in range)
//   word  : selected word, zero for an out-of-range index
module prog_rd_mux #(
  parameter int DATA_W = 32,
  parameter int N_TGT  = 2,
  parameter int TGT_W  = 3
) (
  input  logic [N_TGT*DATA_W-1:0] rdata,
  input  logic [TGT_W-1:0]        sel,
  output logic [DATA_W-1:0]       word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < N_TGT; i++)
      if (sel == TGT_W'(i)) word = rdata[i*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/prog_ctrl_mc.sv
// Debug-port memory programming controller. Takes single-word requests from
// the debug transport and issues them to one of N_TGT memories, with byte
// enables, pointer auto-increment, RD_LAT-cycle reads, out-of-range errors and
// a RST_HOLD-cycle CPU reset pulse when debug mode is left.
//   clk, rst            : clock, synchronous active-high reset
//   dbg_en              : debug mode request (level)
//   req_*               : request channel (valid/ready handshake)
//   rsp_*               : one-cycle response pulse, error flag, read data
//   mem_ctrl_en         : memories muxed to this controller
//   mem_sel/we/re/...   : memory strobes, address, write data, byte enables
//   mem_rdata           : per-target read data, target i at [i*DATA_W +: DATA_W]
//   cpu_rst             : CPU reset request while releasing
module prog_ctrl_mc import prog_pkg::*; #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int N_TGT    = 2,
  parameter int TGT_W    = 3,
  parameter int RD_LAT   = 1,
  parameter int RST_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dbg_en,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    req_incr,
  input  logic [TGT_W-1:0]        req_tgt,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_be,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    mem_ctrl_en,
  output logic [N_TGT-1:0]        mem_sel,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W/8-1:0]     mem_be,
  input  logic [N_TGT*DATA_W-1:0] mem_rdata,
  output logic                    cpu_rst
);

  localparam int BE_W = DATA_W / 8;
  localparam int RDL  = clamp(RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  localparam int HOLD = clamp(RST_HOLD, RST_HOLD_MIN, RST_HOLD_MAX);
  localparam logic [TGT_W:0] NTGT = (TGT_W+1)'(N_TGT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic                we_q, err_q;
  logic [TGT_W-1:0]    tgt_q;
  logic [ADDR_W-1:0]   addr_q, ptr_q, maddr_q, acc_addr;
  logic [DATA_W-1:0]   wdata_q, rdata_q, rd_word;
  logic [BE_W-1:0]     be_q;
  logic                accept, tgt_bad, rd_done, rel_done, acc_ok;

  assign accept   = (state_q == CTRL) && dbg_en && req_valid;
  assign tgt_bad  = {1'b0, req_tgt} >= NTGT;
  assign acc_addr = req_incr ? ptr_q : req_addr;
  // cnt_q restarts on every state change, so it counts cycles spent in the current state
  assign rd_done  = cnt_q == 8'(RDL - 1);
  assign rel_done = cnt_q == 8'(HOLD - 1);

  prog_rd_mux #(.DATA_W(DATA_W), .N_TGT(N_TGT), .TGT_W(TGT_W)) u_rd_mux (
    .rdata (mem_rdata),
    .sel   (tgt_q),
    .word  (rd_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dbg_en) state_d = CTRL;
      CTRL:    if (!dbg_en) state_d = RELEASE;
               else if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = (err_q || we_q) ? RESP : WAIT_RD;
      WAIT_RD: if (rd_done) state_d = RESP;
      // dbg_en loss mid-transaction is only acted on once the response is out
      RESP:    state_d = dbg_en ? CTRL : RELEASE;
      RELEASE: if (rel_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      tgt_q   <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
      if (accept) begin
        we_q   <= req_we;
        tgt_q  <= req_tgt;
        err_q  <= tgt_bad;
        addr_q <= acc_addr;
        // memory-side address/data only move when a real strobe will follow
        if (!tgt_bad) begin
          maddr_q <= acc_addr;
          if (req_we) begin
            wdata_q <= req_wdata;
            be_q    <= req_be;
          end
        end
      end
      if (state_q == ACCESS && (err_q || we_q)) rdata_q <= '0;
      if (state_q == WAIT_RD && rd_done)        rdata_q <= rd_word;
      if (state_q == RESP)                      ptr_q   <= addr_q + ADDR_W'(1);
    end
  end

  assign acc_ok      = (state_q == ACCESS) && !err_q;
  assign req_ready   = state_q == CTRL;
  assign mem_ctrl_en = state_q != IDLE;
  assign cpu_rst     = state_q == RELEASE;
  assign rsp_valid   = state_q == RESP;
  assign rsp_err     = rsp_valid && err_q;
  assign rsp_rdata   = rdata_q;
  assign mem_sel     = acc_ok ? (N_TGT'(1) << tgt_q) : '0;
  assign mem_we      = acc_ok && we_q;
  assign mem_re      = acc_ok && !we_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;

endmodule
